// File: rtl/p2s_serializer.sv
// Parallel-to-serial shifter: sends the low 'len' bits of an accepted word MSB-first, each bit held DIV cycles.
// Accept edge k -> first bit at k, done at k+L*DIV; load_ready low (requests ignored) from accept until the cycle after done.
module p2s_serializer #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [LEN_W-1:0] bits_left;
  logic [DIV_W-1:0] div_cnt;

  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;

  assign load_ready = (state == IDLE);
  assign busy       = !load_ready;

  // Left-align the frame so its first bit (data_in[L-1]) sits at the MSB.
  assign eff_len = (len > WIDTH_L) ? WIDTH_L : len;
  assign aligned = data_in << (WIDTH_L - eff_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bits_left <= '0;
      div_cnt   <= '0;
      ser_out   <= 1'b0;
      ser_en    <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load_valid) begin
            shreg <= aligned;
            if (eff_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= SHIFT;
              ser_en    <= 1'b1;
              ser_out   <= aligned[WIDTH-1];
              bits_left <= eff_len;
              div_cnt   <= DIV_MAX;
            end
          end
        end
        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_ONE;
          end else if (bits_left > ONE_L) begin
            shreg     <= shreg << 1;
            ser_out   <= shreg[WIDTH-2];
            bits_left <= bits_left - ONE_L;
            div_cnt   <= DIV_MAX;
          end else begin
            ser_en  <= 1'b0;
            ser_out <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ser_en  <= 1'b0;
          ser_out <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
// Directed bench for p2s_serializer: a DIV=1 instance (a) and a DIV=3 instance (b) share data/len/reset.
module tb_p2s_serializer;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic [4:0]  len;
  logic        lv_a, lv_b;
  logic        rdy_a, out_a, en_a, busy_a, done_a;
  logic        rdy_b, out_b, en_b, busy_b, done_b;

  int vec_cnt = 0;
  int err_cnt = 0;

  p2s_serializer #(.WIDTH(16), .LEN_W(5), .DIV(1)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .len(len), .load_valid(lv_a),
    .load_ready(rdy_a), .ser_out(out_a), .ser_en(en_a), .busy(busy_a), .done(done_a)
  );

  p2s_serializer #(.WIDTH(16), .LEN_W(5), .DIV(3)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .len(len), .load_valid(lv_b),
    .load_ready(rdy_b), .ser_out(out_b), .ser_en(en_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller has already driven the request at a negedge; the next posedge is accept edge k.
  // Observation j is taken at the negedge following edge k+j.
  task automatic capture(input bit sel, input int max_cyc, input bit keep_valid,
                         input bit swap, input logic [15:0] swap_data,
                         output logic [63:0] ser_word, output int en_cnt,
                         output int done_at, output int done_cnt, output int ready_at);
    ser_word = '0; en_cnt = 0; done_at = -1; done_cnt = 0; ready_at = -1;
    @(posedge clk);
    for (int j = 0; j < max_cyc; j++) begin
      @(negedge clk);
      if (sel ? en_b : en_a) begin
        ser_word = {ser_word[62:0], (sel ? out_b : out_a)};
        en_cnt++;
      end
      if (sel ? done_b : done_a) begin
        if (done_at < 0) done_at = j;
        done_cnt++;
      end
      if ((sel ? rdy_b : rdy_a) && ready_at < 0) ready_at = j;
      if (j == 0) begin
        if (!keep_valid) begin lv_a = 1'b0; lv_b = 1'b0; end
        if (swap) data_in = swap_data;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; data_in = '0; len = '0; lv_a = 1'b0; lv_b = 1'b0;
    #12;
    vec_cnt++; if (out_a !== 1'b0) begin err_cnt++; $display("FAIL reset_ser_out got=%b exp=0", out_a); end
    vec_cnt++; if (en_a !== 1'b0) begin err_cnt++; $display("FAIL reset_ser_en got=%b exp=0", en_a); end
    vec_cnt++; if (done_a !== 1'b0) begin err_cnt++; $display("FAIL reset_done got=%b exp=0", done_a); end
    vec_cnt++; if (rdy_a !== 1'b1) begin err_cnt++; $display("FAIL reset_load_ready got=%b exp=1", rdy_a); end
    vec_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    vec_cnt++; if (rdy_b !== 1'b1) begin err_cnt++; $display("FAIL reset_load_ready_b got=%b exp=1", rdy_b); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_word();
    logic [63:0] w; int en, d_at, d_cnt, r_at;
    data_in = 16'hA5C3; len = 5'd16; lv_a = 1'b1;
    capture(1'b0, 18, 1'b0, 1'b0, 16'h0, w, en, d_at, d_cnt, r_at);
    vec_cnt++; if (w[15:0] !== 16'hA5C3) begin err_cnt++; $display("FAIL full_word got=%h exp=a5c3", w[15:0]); end
    vec_cnt++; if (en !== 16) begin err_cnt++; $display("FAIL full_en_cycles got=%0d exp=16", en); end
    vec_cnt++; if (d_at !== 16) begin err_cnt++; $display("FAIL full_done_at got=%0d exp=16", d_at); end
    vec_cnt++; if (d_cnt !== 1) begin err_cnt++; $display("FAIL full_done_width got=%0d exp=1", d_cnt); end
    vec_cnt++; if (r_at !== 17) begin err_cnt++; $display("FAIL full_ready_at got=%0d exp=17", r_at); end
  endtask

  task automatic test_short();
    logic [63:0] w; int en, d_at, d_cnt, r_at;
    data_in = 16'hFFF9; len = 5'd4; lv_a = 1'b1;
    capture(1'b0, 6, 1'b0, 1'b0, 16'h0, w, en, d_at, d_cnt, r_at);
    vec_cnt++; if (w[3:0] !== 4'b1001) begin err_cnt++; $display("FAIL short_bits got=%b exp=1001", w[3:0]); end
    vec_cnt++; if (en !== 4) begin err_cnt++; $display("FAIL short_en_cycles got=%0d exp=4", en); end
    vec_cnt++; if (d_at !== 4 || d_cnt !== 1) begin err_cnt++; $display("FAIL short_done got_at=%0d got_cnt=%0d exp_at=4 exp_cnt=1", d_at, d_cnt); end
    vec_cnt++; if (r_at !== 5) begin err_cnt++; $display("FAIL short_ready_at got=%0d exp=5", r_at); end
  endtask

  task automatic test_div3();
    logic [63:0] w, exp_w; int en, d_at, d_cnt, r_at;
    logic [15:0] d;
    d = 16'h8001;
    exp_w = '0;
    for (int i = 15; i >= 0; i--)
      for (int r = 0; r < 3; r++) exp_w = {exp_w[62:0], d[i]};
    data_in = d; len = 5'd16; lv_b = 1'b1;
    capture(1'b1, 50, 1'b0, 1'b0, 16'h0, w, en, d_at, d_cnt, r_at);
    vec_cnt++; if (en !== 48) begin err_cnt++; $display("FAIL div3_en_cycles got=%0d exp=48", en); end
    vec_cnt++; if (w[47:0] !== exp_w[47:0]) begin err_cnt++; $display("FAIL div3_seq got=%h exp=%h", w[47:0], exp_w[47:0]); end
    vec_cnt++; if (w[47:45] !== 3'b111 || w[2:0] !== 3'b111) begin err_cnt++; $display("FAIL div3_ends got=%b/%b exp=111/111", w[47:45], w[2:0]); end
    vec_cnt++; if (d_at !== 48 || d_cnt !== 1) begin err_cnt++; $display("FAIL div3_done got_at=%0d got_cnt=%0d exp_at=48 exp_cnt=1", d_at, d_cnt); end
    vec_cnt++; if (r_at !== 49) begin err_cnt++; $display("FAIL div3_ready_at got=%0d exp=49", r_at); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w; int en, d_at, d_cnt, r_at;
    data_in = 16'h1234; len = 5'd16; lv_a = 1'b1;
    // Valid stays high and data switches to 5678 while frame one is in flight.
    capture(1'b0, 18, 1'b1, 1'b1, 16'h5678, w, en, d_at, d_cnt, r_at);
    vec_cnt++; if (w[15:0] !== 16'h1234) begin err_cnt++; $display("FAIL b2b_first got=%h exp=1234", w[15:0]); end
    vec_cnt++; if (en !== 16 || d_at !== 16) begin err_cnt++; $display("FAIL b2b_first_timing got_en=%0d got_done=%0d exp=16/16", en, d_at); end
    vec_cnt++; if (r_at !== 17) begin err_cnt++; $display("FAIL b2b_ready_at got=%0d exp=17", r_at); end
    capture(1'b0, 18, 1'b0, 1'b0, 16'h0, w, en, d_at, d_cnt, r_at);
    vec_cnt++; if (w[15:0] !== 16'h5678) begin err_cnt++; $display("FAIL b2b_second got=%h exp=5678", w[15:0]); end
    vec_cnt++; if (en !== 16 || d_at !== 16) begin err_cnt++; $display("FAIL b2b_second_timing got_en=%0d got_done=%0d exp=16/16", en, d_at); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] w; int en, d_at, d_cnt, r_at; int stray;
    data_in = 16'hAAAA; len = 5'd16; lv_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lv_a = 1'b0;
    repeat (4) @(negedge clk);
    vec_cnt++; if (en_a !== 1'b1) begin err_cnt++; $display("FAIL mid_active got=%b exp=1", en_a); end
    #2 reset = 1'b1;
    #1;
    vec_cnt++; if (en_a !== 1'b0 || out_a !== 1'b0 || done_a !== 1'b0) begin err_cnt++; $display("FAIL mid_async_clear got en=%b out=%b done=%b exp=0/0/0", en_a, out_a, done_a); end
    vec_cnt++; if (rdy_a !== 1'b1 || busy_a !== 1'b0) begin err_cnt++; $display("FAIL mid_async_ready got rdy=%b busy=%b exp=1/0", rdy_a, busy_a); end
    stray = 0;
    repeat (2) begin @(negedge clk); if (done_a || en_a) stray++; end
    reset = 1'b0;
    repeat (3) begin @(negedge clk); if (done_a || en_a) stray++; end
    vec_cnt++; if (stray !== 0) begin err_cnt++; $display("FAIL mid_no_done got=%0d exp=0", stray); end
    data_in = 16'h00FF; len = 5'd8; lv_a = 1'b1;
    capture(1'b0, 10, 1'b0, 1'b0, 16'h0, w, en, d_at, d_cnt, r_at);
    vec_cnt++; if (w[7:0] !== 8'hFF || en !== 8) begin err_cnt++; $display("FAIL mid_after got=%h en=%0d exp=ff en=8", w[7:0], en); end
    vec_cnt++; if (d_at !== 8) begin err_cnt++; $display("FAIL mid_after_done got=%0d exp=8", d_at); end
  endtask

  task automatic test_len_zero();
    logic [63:0] w; int en, d_at, d_cnt, r_at;
    data_in = 16'hFFFF; len = 5'd0; lv_a = 1'b1;
    capture(1'b0, 2, 1'b0, 1'b0, 16'h0, w, en, d_at, d_cnt, r_at);
    vec_cnt++; if (en !== 0) begin err_cnt++; $display("FAIL len0_en got=%0d exp=0", en); end
    vec_cnt++; if (d_at !== 0 || d_cnt !== 1) begin err_cnt++; $display("FAIL len0_done got_at=%0d got_cnt=%0d exp=0/1", d_at, d_cnt); end
    vec_cnt++; if (r_at !== 1) begin err_cnt++; $display("FAIL len0_ready_at got=%0d exp=1", r_at); end
  endtask

  task automatic test_len_clamp();
    logic [63:0] w; int en, d_at, d_cnt, r_at;
    data_in = 16'hC35A; len = 5'd20; lv_a = 1'b1;
    capture(1'b0, 18, 1'b0, 1'b0, 16'h0, w, en, d_at, d_cnt, r_at);
    vec_cnt++; if (en !== 16) begin err_cnt++; $display("FAIL clamp_en got=%0d exp=16", en); end
    vec_cnt++; if (w[15:0] !== 16'hC35A) begin err_cnt++; $display("FAIL clamp_word got=%h exp=c35a", w[15:0]); end
    vec_cnt++; if (d_at !== 16) begin err_cnt++; $display("FAIL clamp_done got=%0d exp=16", d_at); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_short();
    test_div3();
    test_back_to_back();
    test_reset_mid();
    test_len_zero();
    test_len_clamp();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
